// File: rtl/seg_display_if.sv
// Source-select and display-pin bundle shared by the arbiter and whatever drives it.
// The master side supplies select, segment patterns and controls; the slave side drives the pins.
interface seg_display_if #(
   parameter int unsigned NSRC = 4,
   parameter int unsigned NDIG = 8
);
   localparam int unsigned SRC_W = (NSRC > 1) ? $clog2(NSRC) : 1;

   logic [NSRC-1:0]        src_sel;
   logic [NSRC*NDIG*7-1:0] src_seg;
   logic [NDIG-1:0]        blink_mask;
   logic                   display_en;
   logic [NDIG-1:0]        AN;
   logic [6:0]             led;
   logic [SRC_W-1:0]       cur_src;
   logic                   sel_err;

   modport master (
      output src_sel, src_seg, blink_mask, display_en,
      input  AN, led, cur_src, sel_err
   );

   modport slave (
      input  src_sel, src_seg, blink_mask, display_en,
      output AN, led, cur_src, sel_err
   );
endinterface

// File: rtl/seg_display_arbiter.sv
// Multiplexed 7-segment driver that picks one of NSRC sources by one-hot select,
// blanks all digits for BLANK_CYC cycles on a source switch, and supports blink/enable.
module seg_display_arbiter #(
   parameter int unsigned NSRC        = 4,
   parameter int unsigned NDIG        = 8,
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned BLANK_CYC   = 200000,
   parameter int unsigned BLINK_DIV   = 25000000
) (
   input  logic         clk,
   input  logic         rst,
   seg_display_if.slave bus
);
   localparam int unsigned SRC_W   = (NSRC > 1) ? $clog2(NSRC) : 1;
   localparam int unsigned DIG_W   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int unsigned REF_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned BLANK_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
   localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [0:0] ST_SHOW  = 1'b0;
   localparam logic [0:0] ST_BLANK = 1'b1;

   logic [REF_W-1:0]   r_refresh_cnt;
   logic [DIG_W-1:0]   r_digit_idx;
   logic [BLINK_W-1:0] r_blink_cnt;
   logic               r_blink_phase;

   logic [0:0]         r_state,     w_state_nxt;
   logic [BLANK_W-1:0] r_blank_cnt, w_blank_cnt_nxt;
   logic [SRC_W-1:0]   r_cap_idx,   w_cap_idx_nxt;
   logic [SRC_W-1:0]   r_cur_src,   w_cur_src_nxt;

   logic               w_valid;
   logic [SRC_W-1:0]   w_sel_idx;
   logic               w_dark;
   logic [6:0]         w_seg;

   logic [NDIG-1:0]    r_an;
   logic [6:0]         r_led;
   logic               r_sel_err;

   // Digit scan and blink timebase; free-running regardless of FSM or enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_refresh_cnt <= '0;
         r_digit_idx   <= '0;
         r_blink_cnt   <= '0;
         r_blink_phase <= 1'b1;
      end else begin
         if (r_refresh_cnt == REF_W'(REFRESH_DIV - 1)) begin
            r_refresh_cnt <= '0;
            r_digit_idx   <= (r_digit_idx == DIG_W'(NDIG - 1)) ? '0 : r_digit_idx + 1'b1;
         end else begin
            r_refresh_cnt <= r_refresh_cnt + 1'b1;
         end
         if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
         end else begin
            r_blink_cnt   <= r_blink_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      w_sel_idx = '0;
      for (int unsigned i = 0; i < NSRC; i++) begin
         if (bus.src_sel[i]) w_sel_idx = SRC_W'(i);
      end
      w_valid = ($countones(bus.src_sel) == 1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_SHOW;
         r_blank_cnt <= '0;
         r_cap_idx   <= '0;
         r_cur_src   <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_blank_cnt <= w_blank_cnt_nxt;
         r_cap_idx   <= w_cap_idx_nxt;
         r_cur_src   <= w_cur_src_nxt;
      end
   end

   // Invalid selects are ignored entirely; a return to the shown source aborts blanking.
   always_comb begin
      w_state_nxt     = r_state;
      w_blank_cnt_nxt = r_blank_cnt;
      w_cap_idx_nxt   = r_cap_idx;
      w_cur_src_nxt   = r_cur_src;
      case (r_state)
         ST_SHOW: begin
            if (w_valid && (w_sel_idx != r_cur_src)) begin
               w_state_nxt     = ST_BLANK;
               w_blank_cnt_nxt = '0;
               w_cap_idx_nxt   = w_sel_idx;
            end
         end
         ST_BLANK: begin
            if (w_valid && (w_sel_idx == r_cur_src)) begin
               w_state_nxt     = ST_SHOW;
               w_blank_cnt_nxt = '0;
            end else if (w_valid && (w_sel_idx != r_cap_idx)) begin
               w_blank_cnt_nxt = '0;
               w_cap_idx_nxt   = w_sel_idx;
            end else if (r_blank_cnt == BLANK_W'(BLANK_CYC - 1)) begin
               w_state_nxt     = ST_SHOW;
               w_blank_cnt_nxt = '0;
               w_cur_src_nxt   = r_cap_idx;
            end else begin
               w_blank_cnt_nxt = r_blank_cnt + 1'b1;
            end
         end
         default: w_state_nxt = ST_SHOW;
      endcase
   end

   always_comb begin
      w_seg = '0;
      for (int unsigned s = 0; s < NSRC; s++) begin
         for (int unsigned d = 0; d < NDIG; d++) begin
            if ((r_cur_src == SRC_W'(s)) && (r_digit_idx == DIG_W'(d)))
               w_seg = bus.src_seg[(s*NDIG+d)*7 +: 7];
         end
      end
      w_dark = (r_state == ST_BLANK) || !bus.display_en ||
               (bus.blink_mask[r_digit_idx] && !r_blink_phase);
   end

   // Registered pin drivers keep anode/cathode transitions glitch-free.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_an      <= '1;
         r_led     <= 7'h7F;
         r_sel_err <= 1'b0;
      end else begin
         r_an      <= w_dark ? '1 : ~(NDIG'(1) << r_digit_idx);
         r_led     <= w_dark ? 7'h7F : ~w_seg;
         r_sel_err <= !w_valid;
      end
   end

   assign bus.AN      = r_an;
   assign bus.led     = r_led;
   assign bus.cur_src = r_cur_src;
   assign bus.sel_err = r_sel_err;
endmodule
